imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the `cpu` core. It receives a length-prefixed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes those words into instruction memory starting at address 0 and holds the core in reset until the image is complete. Once loading finishes it releases `cpu_rst`, so the core fetches from PC=0 with the freshly loaded program.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader.sv | 114 +++++++++++
 tb/tb_imem_loader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and word/byte widths for the boot loader
package imem_loader_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    CHK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte stream to imem word writer; holds the core in reset until loaded
// Optional trailing XOR checksum byte: IMEM_LOADER_CHECKSUM_EN
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam logic [BYTE_W-1:0] DEPTH_B = BYTE_W'(DEPTH);

  state_t            state, state_next;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   cnt_next;
  logic [ADDR_W:0]   n_len;
  logic [BYTE_W-1:0] hi_byte;
  logic              accept;
  logic              len_bad;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] chk_acc;
`endif

  // in_ready is a register, so the handshake never depends combinationally on in_valid
  assign accept   = in_valid && in_ready;
  assign cnt_next = word_cnt + 1'b1;
  assign len_bad  = (in_data == '0) || (in_data > DEPTH_B);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = len_bad ? ERROR : HI;
      HI:   if (accept) state_next = LO;
      LO: begin
        if (accept) begin
          if (cnt_next == n_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_next = CHK;
`else
            state_next = DONE;
`endif
          end else begin
            state_next = HI;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:  if (accept) state_next = (in_data == chk_acc) ? DONE : ERROR;
`endif
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_cnt   <= '0;
      n_len      <= '0;
      hi_byte    <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state    <= state_next;
      // Drop ready on the same edge that enters a terminal state so trailing bytes stay unconsumed
      in_ready <= (state_next != DONE) && (state_next != ERROR);
      imem_we  <= 1'b0;
      done     <= (state == DONE);
      cpu_rst  <= (state != DONE);
      error    <= (state == ERROR);
      if (accept) begin
        case (state)
          IDLE: n_len   <= (ADDR_W+1)'(in_data);
          HI:   hi_byte <= in_data;
          LO: begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt[ADDR_W-1:0];
            imem_wdata <= {hi_byte, in_data};
            word_cnt   <= cnt_next;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over the length byte and every payload byte
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_acc <= '0;
    end else if (accept && (state == IDLE || state == HI || state == LO)) begin
      chk_acc <= chk_acc ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench for imem_loader with a write scoreboard
module tb_imem_loader;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;

  int vectors = 0;
  int miscompares = 0;

  logic [ADDR_W+15:0] exp_q[$];
  logic [15:0]        wbuf[0:DEPTH-1];
  logic [7:0]         chk;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected (addr, data)
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {27'd0, imem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [ADDR_W+15:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, imem_addr}, {27'd0, e[ADDR_W+15:16]});
        check("wr_data", {16'd0, imem_wdata}, {16'd0, e[15:0]});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {27'd0, imem_addr}, 32'd0);
    check("rst_wdata", {16'd0, imem_wdata}, 32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_done_err", {30'd0, done, error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int t;
    t = 0;
    @(negedge clk);
    if (gap) begin
      check("gap_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_timeout", {31'd0, (t < 50)}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Streams N words from wbuf; returns right after the last accepted byte's edge
  task automatic load(input int n, input bit gap);
    chk = 8'(n);
    send(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({ADDR_W'(i), wbuf[i]});
      send(wbuf[i][15:8], gap);
      send(wbuf[i][7:0], gap);
      chk = chk ^ wbuf[i][15:8] ^ wbuf[i][7:0];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(chk, gap);
`else
    check("last_we", {31'd0, imem_we}, 32'd1);
`endif
    check("pre_done_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("pre_done_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check("done", {31'd0, done}, 32'd1);
    check("cpu_rst_released", {31'd0, cpu_rst}, 32'd0);
    check("done_ready", {31'd0, in_ready}, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);
  endtask

  task automatic expect_error();
    @(posedge clk); #1;
    check("err_flag", {31'd0, error}, 32'd1);
    check("err_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("err_done", {31'd0, done}, 32'd0);
    check("err_ready", {31'd0, in_ready}, 32'd0);
    check("err_sb_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    do_reset();

    // Basic N=2 image
    wbuf[0] = 16'h0123;
    wbuf[1] = 16'h4567;
    load(2, 1'b0);

    // Trailing byte after DONE must not be consumed
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h99;
    repeat (3) begin
      @(posedge clk); #1;
      check("extra_ready", {31'd0, in_ready}, 32'd0);
      check("extra_done", {31'd0, done}, 32'd1);
    end
    in_valid = 1'b0;

    // Same image with in_valid gaps
    do_reset();
    load(2, 1'b1);

    // N=0 and N=DEPTH+1 are rejected
    do_reset();
    send(8'h00, 1'b0);
    expect_error();
    do_reset();
    send(8'(DEPTH + 1), 1'b0);
    expect_error();

    // Full depth image, last write at DEPTH-1
    do_reset();
    for (int i = 0; i < DEPTH; i++) wbuf[i] = 16'(i * 16'h0707 + 16'h1234);
    load(DEPTH, 1'b0);

    // Reset after three payload bytes, then a fresh one-word image
    do_reset();
    exp_q.push_back({ADDR_W'(0), 16'h0123});
    send(8'h02, 1'b0);
    send(8'h01, 1'b0);
    send(8'h23, 1'b0);
    send(8'h45, 1'b0);
    do_reset();
    check("mid_rst_sb", exp_q.size(), 32'd0);
    wbuf[0] = 16'hABCD;
    load(1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum
    do_reset();
    exp_q.push_back({ADDR_W'(0), 16'h0123});
    exp_q.push_back({ADDR_W'(1), 16'h4567});
    send(8'h02, 1'b0);
    send(8'h01, 1'b0);
    send(8'h23, 1'b0);
    send(8'h45, 1'b0);
    send(8'h67, 1'b0);
    send(8'hFF, 1'b0);
    expect_error();
`endif

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
